// File: rtl/fa_pkg.sv
// fa_pkg: FSM state encoding and chunk-count / index-width helpers for fa_nbits_seq
package fa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fa_state_t;
  function automatic int fa_nch(input int w, input int c);
    return w / c;
  endfunction
  function automatic int fa_idx_w(input int w, input int c);
    return (w / c > 1) ? $clog2(w / c) : 1;
  endfunction
endpackage

// File: rtl/fa_chunk.sv
// fa_chunk: W-bit ripple adder of full adders; ports a,b,ci -> s,co plus msb_ci (carry into top bit)
module fa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         msb_ci
);
  logic [W:0] c;
  assign c[0] = ci;
  for (genvar g = 0; g < W; g++) begin : g_fa
    assign s[g]   = a[g] ^ b[g] ^ c[g];
    assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
  assign co     = c[W];
  assign msb_ci = c[W-1];
endmodule

// File: rtl/fa_nbits_seq.sv
// fa_nbits_seq: chunk-serial add/sub; in_valid/in_ready + i0,i1,cin,sub in; out_valid/out_ready + sum,cout,ovf out
module fa_nbits_seq
  import fa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCH = fa_nch(WIDTH, CHUNK);
  localparam int IW  = fa_idx_w(WIDTH, CHUNK);
  fa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co, ch_msb_ci, last;
  fa_chunk #(.W(CHUNK)) u_chunk (
    .a      (a_q[idx_q*CHUNK +: CHUNK]),
    .b      (b_q[idx_q*CHUNK +: CHUNK]),
    .ci     (carry_q),
    .s      (ch_s),
    .co     (ch_co),
    .msb_ci (ch_msb_ci)
  );
  assign last      = idx_q == IW'(NCH - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;
  // Subtraction is i0 + ~i1 + ~cin, so the borrow-in becomes an inverted carry-in.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = i0;
        b_d     = sub ? ~i1 : i1;
        carry_d = sub ? ~cin : cin;
        sum_d   = '0;
        ovf_d   = 1'b0;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = ch_s;
        carry_d = ch_co;
        ovf_d   = last ? ch_msb_ci ^ ch_co : ovf_q;
        idx_d   = last ? '0 : idx_q + IW'(1);
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: doc/fa_nbits_seq.md
FA_NBITS_SEQ -- requirements
Module: fa_nbits_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  block can accept operands.
REQ-007 Port i0  input  WIDTH  first operand.
REQ-008 Port i1  input  WIDTH  second operand.
REQ-009 Port cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 Port sub  input  1  0 = add, 1 = subtract.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port sum  output  WIDTH  result.
REQ-014 Port cout  output  1  raw carry out of MSB.
REQ-015 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; NCH = WIDTH/CHUNK.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid&&in_ready, register i0, i1 (inverted if sub=1), carry = sub ? ~cin : cin; chunk index = 0; go RUN.
REQ-019 RUN: each cycle adds chunk [idx*CHUNK +: CHUNK] of both registered operands plus carry register; writes that chunk of sum; carry register takes chunk carry-out; idx increments.
REQ-020 RUN to DONE after the cycle processing idx = NCH-1; out_valid rises exactly NCH cycles after the accepting edge.
REQ-021 Add result: {cout,sum} = i0 + i1 + cin modulo 2^(WIDTH+1).
REQ-022 Subtract result: sum = i0 - i1 - cin mod 2^WIDTH; cout = 1 when no borrow.
REQ-023 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 DONE: sum, cout, ovf held stable until out_valid&&out_ready, then go IDLE.
REQ-025 in_valid, i0, i1, cin, sub changes outside IDLE SHALL be ignored.
REQ-026 CHUNK = WIDTH SHALL give NCH = 1 (single RUN cycle); no wrap of idx beyond NCH-1.
REQ-027 Throughput: one operation per NCH+2 cycles minimum (no overlap of accept and output handshake).

Reset
REQ-028 rst asserted SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
REQ-029 rst during RUN or DONE SHALL abort the operation; no result is ever emitted for it.
REQ-030 First accept allowed on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package fa_pkg SHALL hold the FSM state encoding and the NCH/index-width derivation function.
REQ-032 One sub-module fa_chunk (combinational CHUNK-bit ripple adder of 1-bit full adders, exposing MSB carry-in and carry-out) SHALL be instantiated once.

Verification (WIDTH=16, CHUNK=4)
REQ-033 add 0xFFFF+0x0001, cin=0 -> out_valid after 4 cycles, sum=0x0000, cout=1, ovf=0.
REQ-034 add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-035 sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
REQ-036 out_ready held 0 for 5 cycles in DONE, in_valid toggled meanwhile -> sum/cout/ovf constant, in_ready=0, no new capture.
REQ-037 rst pulsed at RUN idx=2 -> all outputs 0 asynchronously, in_ready=1, no out_valid for aborted op; next op 0x1234+0x1111 -> 0x2345.
REQ-038 Back-to-back ops with out_ready=1 -> in_ready high exactly one cycle after each output handshake; results match REQ-021.
